// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port word RAM answering CPU loads/stores after a fixed wait
// Requests are latched in IDLE; the RAM access and the one-cycle ack happen on the edge leaving RESP.
module mem_responder #(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        mem_err_o,
  output logic        busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [3:0]        r_sel;
  logic [31:0]       r_data;
  logic [31:0]       r_dout;
  logic              r_ack;
  logic              r_err;
  logic [31:0]       r_mem [0:(1 << ADDR_W) - 1];

  logic [ADDR_W-1:0] w_idx;
  logic              w_hi;
  logic              w_err;
  logic              w_resp;

  assign w_idx  = r_addr[ADDR_W+1:2];
  assign w_hi   = (r_addr >> (ADDR_W + 2)) != 32'd0;
  assign w_err  = (r_addr[1:0] != 2'b00) || w_hi || (r_sel == 4'b0000);
  assign w_resp = (r_state == S_RESP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_sel   <= 4'd0;
      r_data  <= 32'd0;
      r_dout  <= 32'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= w_resp;
      r_err <= w_resp && w_err;
      case (r_state)
        S_IDLE: begin
          if (mem_ce_i) begin
            r_we   <= mem_we_i;
            r_addr <= mem_addr_i;
            r_sel  <= mem_sel_i;
            r_data <= mem_data_i;
            r_cnt  <= CNT_INIT;
            r_state <= (WAIT_CYC > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          // Stores never touch the read port; erroneous loads return zero.
          if (!r_we) begin
            r_dout <= w_err ? 32'd0 : r_mem[w_idx];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM has no reset; a reset edge suppresses the pending write.
  always_ff @(posedge clk) begin
    if (rst && w_resp && r_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (r_sel[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_data[8*i +: 8];
        end
      end
    end
  end

  assign mem_data_o = r_dout;
  assign mem_ack_o  = r_ack;
  assign mem_err_o  = r_err;
  assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (WAIT_CYC=2 and WAIT_CYC=0 instances)
module tb_mem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] dout, dout0;
  logic        ack, ack0, err, err0, busy, busy0;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  logic [31:0] m_mem [256];
  logic [31:0] m_dout;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .WAIT_CYC(W)) dut (
    .clk(clk), .rst(rst), .mem_ce_i(ce), .mem_we_i(we), .mem_addr_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(dout), .mem_ack_o(ack),
    .mem_err_o(err), .busy_o(busy)
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .mem_ce_i(ce), .mem_we_i(we), .mem_addr_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(dout0), .mem_ack_o(ack0),
    .mem_err_o(err0), .busy_o(busy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_err(input logic [31:0] a, input logic [3:0] s);
    return (a % 4 != 0) || (a >= 32'd1024) || (s == 4'd0);
  endfunction

  task automatic m_apply(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int idx;
    idx = int'(a / 4);
    if (m_err(a, s)) begin
      if (!w) m_dout = 32'd0;
    end else if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
    end else begin
      m_dout = m_mem[idx];
    end
  endtask

  task automatic do_req(input string name, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic exp_err, input logic [31:0] exp_data);
    int n;
    bit got;
    @(negedge clk);
    ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
    @(posedge clk);
    #1;
    ce = 1'b0;
    chk({name, ".busy_e0"}, busy, 1);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (ack) got = 1'b1;
    end
    chk({name, ".latency"}, n, W + 1);
    chk({name, ".err"}, err, exp_err);
    chk({name, ".data"}, dout, exp_data);
    @(posedge clk);
    #1;
    chk({name, ".ack_fall"}, ack, 0);
    chk({name, ".busy_after"}, busy, 0);
  endtask

  task automatic model_req(input string name, input logic w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d);
    logic e;
    e = m_err(a, s);
    m_apply(w, a, s, d);
    do_req(name, w, a, s, d, e, m_dout);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((err && !ack) || (err0 && !ack0)) begin
        errors++;
        $display("FAIL err_without_ack: err=%b ack=%b err0=%b ack0=%b", err, ack, err0, ack0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    logic        w;
    int          r;

    tbl[0] = '{1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 1'b0, 32'h00000000};
    tbl[1] = '{1'b0, 32'h10,  4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h10,  4'h5, 32'h11223344, 1'b0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 32'h10,  4'hF, 32'h0,        1'b0, 32'hDE22BE44};
    tbl[4] = '{1'b0, 32'h12,  4'hF, 32'h0,        1'b1, 32'h00000000};
    tbl[5] = '{1'b1, 32'h00,  4'hF, 32'h01020304, 1'b0, 32'h00000000};
    tbl[6] = '{1'b1, 32'h400, 4'hF, 32'hCAFEF00D, 1'b1, 32'h00000000};
    tbl[7] = '{1'b0, 32'h00,  4'hF, 32'h0,        1'b0, 32'h01020304};
    tbl[8] = '{1'b1, 32'h10,  4'h0, 32'hFFFFFFFF, 1'b1, 32'h01020304};
    tbl[9] = '{1'b0, 32'h10,  4'h1, 32'h0,        1'b0, 32'hDE22BE44};

    // Reset with a request pending on the inputs: it must not be taken.
    rst = 1'b0; ce = 1'b1; we = 1'b1; addr = 32'h0; sel = 4'hF; wdata = 32'hFFFFFFFF;
    m_dout = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.ack", ack, 0);
    chk("rst.err", err, 0);
    chk("rst.data", dout, 0);
    chk("rst.busy0", busy0, 0);
    chk("rst.data0", dout0, 0);
    @(negedge clk);
    rst = 1'b1; ce = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.no_accept", busy, 0);

    for (int i = 0; i < 10; i++) begin
      do_req($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].data,
             tbl[i].exp_err, tbl[i].exp_data);
      m_apply(tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].data);
    end

    for (int i = 0; i < 16; i++)
      model_req($sformatf("fill%0d", i), 1'b1, 32'(i * 4), 4'hF, $urandom);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) << 2;
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = a | (32'd1 << $urandom_range(10, 31));
      s = 4'($urandom);
      if (r == 2) s = 4'd0;
      w = 1'($urandom);
      model_req($sformatf("rnd%0d", i), w, a, s, $urandom);
    end

    // Back-to-back loads with ce held high for 12 edges.
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'hF;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 11) ce = 1'b0;
      chk($sformatf("b2b.ack%0d", k), ack, (k % (W + 2)) == (W + 1));
      chk($sformatf("b2b.busy%0d", k), busy, (k % (W + 2)) != (W + 1));
      if (ack) chk($sformatf("b2b.data%0d", k), dout, m_mem[4]);
    end
    m_dout = m_mem[4];
    @(posedge clk);
    #1;
    chk("b2b.busy_end", busy, 0);
    repeat (2) @(posedge clk);

    // Reset in the middle of a store.
    model_req("pre_rst", 1'b1, 32'h20, 4'hF, 32'hA5A5A5A5);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'hF; wdata = 32'h12345678;
    @(posedge clk);
    #1;
    ce = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.ack", ack, 0);
    chk("midrst.data", dout, 0);
    m_dout = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst.no_ack%0d", k), ack, 0);
    end
    model_req("post_rst", 1'b0, 32'h20, 4'hF, 32'h0);

    // Zero-wait instance: ack the edge after acceptance, busy for one cycle only.
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'hF;
    @(posedge clk);
    #1;
    ce = 1'b0;
    chk("w0.busy_e0", busy0, 1);
    chk("w0.ack_e0", ack0, 0);
    @(posedge clk);
    #1;
    chk("w0.ack_e1", ack0, 1);
    chk("w0.err_e1", err0, 0);
    chk("w0.busy_e1", busy0, 0);
    chk("w0.data_e1", dout0, m_mem[4]);
    @(posedge clk);
    #1;
    chk("w0.ack_e2", ack0, 0);
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width (RAM depth 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_CYC, default 2, number of wait cycles inserted before each response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (rst==0 sampled at a clk edge resets the block).
REQ-005 SHALL have port mem_ce_i  input  1  CPU request strobe.
REQ-006 SHALL have port mem_we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port mem_addr_i  input  32  byte address.
REQ-008 SHALL have port mem_sel_i  input  4  byte enables; sel[i] selects data bits [8i+7:8i].
REQ-009 SHALL have port mem_data_i  input  32  store data.
REQ-010 SHALL have port mem_data_o  output  32  load data, registered.
REQ-011 SHALL have port mem_ack_o  output  1  one-cycle response pulse, registered.
REQ-012 SHALL have port mem_err_o  output  1  error flag, valid only with mem_ack_o, registered.
REQ-013 SHALL have port busy_o  output  1  high while a request is outstanding (WAIT or RESP).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 IDLE: mem_ce_i==1 at edge E0 SHALL latch we, addr, sel, data and go to WAIT (WAIT_CYC>0) or RESP (WAIT_CYC==0).
REQ-016 IDLE with mem_ce_i==0 SHALL remain IDLE; no RAM access.
REQ-017 WAIT: 4-bit counter loaded with WAIT_CYC-1 at E0, decremented each edge; at the edge it reads 0, SHALL go to RESP.
REQ-018 Latency: mem_ack_o SHALL rise at edge E0+WAIT_CYC+1 and fall at the next edge (exactly one cycle high).
REQ-019 RESP SHALL always return to IDLE on the next edge; minimum request spacing is WAIT_CYC+2 cycles.
REQ-020 mem_ce_i, mem_addr_i, mem_we_i, mem_sel_i, mem_data_i SHALL be ignored in WAIT and RESP (latched copy used).
REQ-021 mem_ce_i still high in IDLE after a response SHALL be accepted as a new request.
REQ-022 Error condition: latched addr[1:0]!=0, or latched addr[31:ADDR_W+2]!=0, or latched sel==4'b0000.
REQ-023 Valid store: at the edge ack rises, SHALL write only enabled bytes of RAM[addr[ADDR_W+1:2]]; disabled bytes unchanged; mem_data_o unchanged.
REQ-024 Valid load: at the edge ack rises, mem_data_o SHALL load RAM[addr[ADDR_W+1:2]] full word (sel ignored for reads).
REQ-025 Error: no RAM write; mem_err_o=1 with ack; load returns mem_data_o=0; store leaves mem_data_o unchanged.
REQ-026 mem_err_o SHALL be 0 whenever mem_ack_o is 0.
REQ-027 mem_data_o SHALL hold its value between loads.
REQ-028 busy_o SHALL be 1 exactly in WAIT and RESP.

Reset
REQ-029 rst==0 at an edge SHALL force IDLE, counter 0, mem_ack_o=0, mem_err_o=0, busy_o=0, mem_data_o=0, in any state.
REQ-030 Reset mid-request SHALL discard the pending operation: no RAM write, no ack.
REQ-031 Reset SHALL NOT clear RAM contents; RAM initial contents undefined.
REQ-032 Request presented during the reset edge SHALL NOT be accepted.

Verification
REQ-033 WAIT_CYC=2: store addr 0x10, sel 4'hF, data 0xDEADBEEF at E0 -> ack high E3..E4, err 0; load 0x10 -> mem_data_o 0xDEADBEEF with ack.
REQ-034 Byte enable: RAM[0x10]=0xDEADBEEF, store sel 4'b0101 data 0x11223344 -> load reads 0xDE22BE44.
REQ-035 Errors: load addr 0x12 -> ack+err, mem_data_o 0; store addr 0x400 (ADDR_W=8) -> ack+err, RAM unchanged; sel 0 store -> ack+err.
REQ-036 Back-to-back: mem_ce_i held high 12 cycles, WAIT_CYC=2 -> acks every 4 cycles, busy_o low exactly one cycle between them.
REQ-037 Reset mid-op: store accepted E0, rst=0 at E2 -> no ack, busy_o 0 after E2, target word keeps old value on later load.
REQ-038 WAIT_CYC=0: request at E0 -> ack high E1..E2, never enters WAIT.
